// File: rtl/fifo_burst_sched.sv
// fifo_burst_sched: round-robin burst/tail request scheduler for CH write FIFOs.
// One AXI write-burst request is outstanding at a time; each request is either
// a full THRESHOLD-beat burst or a tail flush of a channel's remaining words.
module fifo_burst_sched #(
  parameter int CH        = 2,
  parameter int CW        = 10,
  parameter int LSIZE     = 9,
  parameter int THRESHOLD = 200,
  parameter int CHW       = 1
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [CH*CW-1:0]   count,
  input  logic [CH-1:0]      tail,
  input  logic [CH-1:0]      fifo_empty,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [CHW-1:0]     req_ch,
  output logic [LSIZE-1:0]   req_len,
  output logic               req_tail,
  input  logic               done,
  output logic [CH-1:0]      tail_ack,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE, FSH} state_t;

  // THRESHOLD must fit both the fill-count width and the request length width.
  localparam logic [CW-1:0]    THR_CNT = CW'(THRESHOLD);
  localparam logic [LSIZE-1:0] THR_LEN = LSIZE'(THRESHOLD);

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_ch [CH];
  logic [LSIZE-1:0] len_ch [CH];
  logic [CH-1:0]    burst_elig_reg, burst_elig_next;
  logic [CH-1:0]    tail_pend_reg, tail_pend_next;
  logic [CH-1:0]    eligible;
  logic [CHW-1:0]   last_grant_reg, last_grant_next;
  logic [CHW-1:0]   req_ch_reg, req_ch_next;
  logic [LSIZE-1:0] req_len_reg, req_len_next;
  logic             req_tail_reg, req_tail_next;
  logic             accept;
  logic             grant_found;
  logic [CHW-1:0]   grant_idx;
  logic             grant_burst;
  logic [LSIZE-1:0] grant_len;

  assign accept = (state_reg == REQ) && req_ready;

  // Per-channel slicing, eligibility and flag next-state.
  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      assign count_ch[gi] = count[gi*CW +: CW];

      // Tail length is the low LSIZE bits of the fill count.
      if (LSIZE <= CW) begin : g_trunc
        assign len_ch[gi] = count_ch[gi][LSIZE-1:0];
      end else begin : g_ext
        assign len_ch[gi] = {{(LSIZE-CW){1'b0}}, count_ch[gi]};
      end

      assign burst_elig_next[gi] = count_ch[gi] > THR_CNT;

      assign eligible[gi] = !fifo_empty[gi] &&
                            (burst_elig_reg[gi] || (tail_pend_reg[gi] && count_ch[gi] != '0));

      // A new tail pulse always wins over a clear in the same cycle.
      assign tail_pend_next[gi] =
        tail[gi] ? 1'b1 :
        ((accept && req_tail_reg && (req_ch_reg == CHW'(gi))) ||
         ((state_reg == IDLE) && (count_ch[gi] == '0))) ? 1'b0 :
        tail_pend_reg[gi];
    end
  endgenerate

  // Round-robin search starting just after the last accepted channel.
  always_comb begin
    int c;
    c           = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_burst = 1'b0;
    grant_len   = '0;
    for (int k = 1; k <= CH; k++) begin
      c = int'(last_grant_reg) + k;
      if (c >= CH) c = c - CH;
      if (!grant_found && eligible[c]) begin
        grant_found = 1'b1;
        grant_idx   = CHW'(c);
        grant_burst = burst_elig_reg[c];
        grant_len   = len_ch[c];
      end
    end
  end

  // Next-state logic and request latching.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    req_ch_next     = req_ch_reg;
    req_len_next    = req_len_reg;
    req_tail_next   = req_tail_reg;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          state_next  = REQ;
          req_ch_next = grant_idx;
          // A full burst takes priority over a tail flush on the same channel.
          if (grant_burst) begin
            req_len_next  = THR_LEN;
            req_tail_next = 1'b0;
          end else begin
            req_len_next  = grant_len;
            req_tail_next = 1'b1;
          end
        end
      end
      REQ: begin
        if (req_ready) begin
          state_next      = WAIT_DONE;
          last_grant_next = req_ch_reg;
        end
      end
      WAIT_DONE: begin
        if (done) state_next = FSH;
      end
      FSH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Per-channel flags, round-robin pointer and latched request fields.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      burst_elig_reg <= '0;
      tail_pend_reg  <= '0;
      last_grant_reg <= CHW'(CH-1);
      req_ch_reg     <= '0;
      req_len_reg    <= '0;
      req_tail_reg   <= 1'b0;
    end else begin
      burst_elig_reg <= burst_elig_next;
      tail_pend_reg  <= tail_pend_next;
      last_grant_reg <= last_grant_next;
      req_ch_reg     <= req_ch_next;
      req_len_reg    <= req_len_next;
      req_tail_reg   <= req_tail_next;
    end
  end

  // Outputs decoded from state and latched request fields.
  always_comb begin
    req_valid = (state_reg == REQ);
    busy      = (state_reg != IDLE);
    req_ch    = req_ch_reg;
    req_len   = req_len_reg;
    req_tail  = req_tail_reg;
    tail_ack  = '0;
    for (int i = 0; i < CH; i++) begin
      tail_ack[i] = (state_reg == FSH) && req_tail_reg && (req_ch_reg == CHW'(i));
    end
  end

endmodule

// File: tb/tb_fifo_burst_sched.sv
// Testbench for fifo_burst_sched: directed and randomized steps checked
// against a transaction-level model of the scheduling rules.
module tb_fifo_burst_sched;
  localparam int CH  = 2;
  localparam int CW  = 10;
  localparam int LS  = 9;
  localparam int THR = 200;
  localparam int CHW = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CH*CW-1:0] count;
  logic [CH-1:0]    tail;
  logic [CH-1:0]    fifo_empty;
  logic             req_valid;
  logic             req_ready;
  logic [CHW-1:0]   req_ch;
  logic [LS-1:0]    req_len;
  logic             req_tail;
  logic             done;
  logic [CH-1:0]    tail_ack;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: fill counts, pending tails, last accepted channel.
  int m_cnt [CH];
  bit m_tp  [CH];
  int m_last;

  always #5 clk = ~clk;

  fifo_burst_sched #(.CH(CH), .CW(CW), .LSIZE(LS), .THRESHOLD(THR), .CHW(CHW)) dut (
    .clock(clk), .rst_n(rst_n), .count(count), .tail(tail), .fifo_empty(fifo_empty),
    .req_valid(req_valid), .req_ready(req_ready), .req_ch(req_ch), .req_len(req_len),
    .req_tail(req_tail), .done(done), .tail_ack(tail_ack), .busy(busy)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_counts(input int c0, input int c1);
    m_cnt[0]   = c0;
    m_cnt[1]   = c1;
    count      = {CW'(c1), CW'(c0)};
    fifo_empty = {c1 == 0, c0 == 0};
  endtask

  task automatic pulse_tail(input logic [CH-1:0] t);
    tail = t;
    for (int c = 0; c < CH; c++) if (t[c]) m_tp[c] = 1'b1;
    @(negedge clk);
    tail = '0;
  endtask

  // Which request should come next given the current model state.
  function automatic void predict(output bit any, output int ch, output int len, output bit tl);
    any = 1'b0; ch = 0; len = 0; tl = 1'b0;
    for (int c = 0; c < CH; c++) if (m_cnt[c] == 0) m_tp[c] = 1'b0;
    for (int k = 1; k <= CH; k++) begin
      int c;
      c = (m_last + k) % CH;
      if (!any && m_cnt[c] != 0 && (m_cnt[c] > THR || m_tp[c])) begin
        any = 1'b1;
        ch  = c;
        tl  = !(m_cnt[c] > THR);
        len = tl ? m_cnt[c] : THR;
      end
    end
  endfunction

  // Expect the next request (or none), serve it with immediate ready/done,
  // then apply new counts and tail pulses while the engine is busy.
  task automatic do_req(input int nc0, input int nc1, input logic [CH-1:0] nt, input bit retail);
    bit any; int ch; int len; bit tl; int waited;
    predict(any, ch, len, tl);
    if (!any) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("no_req", req_valid, 0);
      end
      drive_counts(nc0, nc1);
      pulse_tail(nt);
      chk("no_req_after", req_valid, 0);
      $display("txn none");
      return;
    end
    waited = 0;
    while (req_valid !== 1'b1 && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    chk("req_seen", req_valid, 1);
    if (req_valid !== 1'b1) return;
    chk("req_ch", req_ch, ch);
    chk("req_len", req_len, len);
    chk("req_tail", req_tail, tl);
    $display("txn ch=%0d len=%0d tail=%0d", req_ch, req_len, req_tail);
    req_ready = 1'b1;
    if (retail) tail[ch] = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    tail      = '0;
    m_last = ch;
    if (tl) m_tp[ch] = 1'b0;
    if (retail) m_tp[ch] = 1'b1;
    chk("accepted", req_valid, 0);
    chk("busy_wait", busy, 1);
    drive_counts(nc0, nc1);
    tail = nt;
    for (int c = 0; c < CH; c++) if (nt[c]) m_tp[c] = 1'b1;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    tail = '0;
    chk("tail_ack", tail_ack, tl ? (32'd1 << ch) : 32'd0);
    chk("busy_fsh", busy, 1);
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("tail_ack_clear", tail_ack, 0);
  endtask

  function automatic int rnd_cnt();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return int'($urandom_range(1, THR));
      default: return int'($urandom_range(THR + 1, 1000));
    endcase
  endfunction

  initial begin
    int waited;
    rst_n = 1'b0; tail = '0; req_ready = 1'b0; done = 1'b0;
    drive_counts(0, 0);
    m_last = CH - 1;
    for (int c = 0; c < CH; c++) m_tp[c] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", req_valid, 0);
    chk("rst_ch", req_ch, 0);
    chk("rst_len", req_len, 0);
    chk("rst_tail", req_tail, 0);
    chk("rst_ack", tail_ack, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Crossing the threshold: valid rises two cycles after the count change.
    drive_counts(201, 0);
    @(negedge clk);
    chk("cross_lat1", req_valid, 0);
    @(negedge clk);
    chk("cross_lat2", req_valid, 1);
    do_req(0, 0, 2'b00, 1'b0);

    // Count equal to the threshold is not a burst.
    drive_counts(200, 0);
    do_req(250, 250, 2'b00, 1'b0);

    // Both channels full: grants alternate.
    do_req(250, 250, 2'b00, 1'b0);
    do_req(250, 250, 2'b00, 1'b0);
    do_req(250, 250, 2'b00, 1'b0);
    do_req(0, 0, 2'b00, 1'b0);

    // Tail flush of channel 1.
    drive_counts(0, 37);
    pulse_tail(2'b10);
    do_req(0, 0, 2'b00, 1'b0);

    // Tail pending with a large count: burst first, then tail.
    drive_counts(300, 0);
    pulse_tail(2'b01);
    do_req(100, 0, 2'b00, 1'b0);
    do_req(0, 0, 2'b00, 1'b0);

    // Tail with empty count is dropped; later data does not revive it.
    pulse_tail(2'b01);
    do_req(50, 0, 2'b00, 1'b0);
    do_req(50, 0, 2'b00, 1'b0);

    // Tail re-pulsed on its own accept cycle yields a second tail request.
    pulse_tail(2'b01);
    do_req(50, 0, 2'b00, 1'b1);
    do_req(0, 0, 2'b00, 1'b0);

    // Randomized traffic.
    for (int it = 0; it < 16; it++) begin
      do_req(rnd_cnt(), rnd_cnt(), CH'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    do_req(0, 0, 2'b00, 1'b0);
    do_req(0, 0, 2'b00, 1'b0);

    // Stalled request holds its fields while counts move.
    drive_counts(0, 120);
    pulse_tail(2'b10);
    waited = 0;
    while (req_valid !== 1'b1 && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    chk("stall_seen", req_valid, 1);
    for (int i = 0; i < 5; i++) begin
      drive_counts(int'($urandom_range(201, 900)), int'($urandom_range(1, THR)));
      @(negedge clk);
      chk("stall_valid", req_valid, 1);
      chk("stall_ch", req_ch, 1);
      chk("stall_len", req_len, 120);
      chk("stall_tail", req_tail, 1);
    end
    $display("txn stalled ch=%0d len=%0d tail=%0d", req_ch, req_len, req_tail);

    // Reset during WAIT_DONE clears outputs at once and drops pending tails.
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", req_valid, 0);
    chk("arst_ch", req_ch, 0);
    chk("arst_len", req_len, 0);
    chk("arst_tail", req_tail, 0);
    chk("arst_ack", tail_ack, 0);
    chk("arst_busy", busy, 0);
    drive_counts(0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = CH - 1;
    for (int c = 0; c < CH; c++) m_tp[c] = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    drive_counts(0, 50);
    do_req(0, 0, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_burst_sched.md
# fifo_burst_sched

Multi-channel successor to the single-FIFO burst/tail request controller. It watches the fill level of `CH` write-side FIFOs and issues one AXI write-burst request at a time to the shared VDMA write engine. Each request is either a full burst of `THRESHOLD` beats or a tail flush of the remaining words. Grants rotate round-robin across channels, and a latched tail flag per channel guarantees end-of-frame residue is written out.

## Interface
Parameters:
- `CH`, 2: number of FIFO channels (1..16)
- `CW`, 10: width of each per-channel fill count
- `LSIZE`, 9: width of `req_len`; requires `THRESHOLD < 2**LSIZE`
- `THRESHOLD`, 200: full-burst length and burst trigger level
- `CHW`, 1: width of `req_ch`; must be ≥ clog2(`CH`), minimum 1

Ports:
- `clock` in 1: single clock, all logic rising-edge
- `rst_n` in 1: asynchronous, active-low reset
- `count` in CH*CW: packed fill counts; channel i is at [i*CW +: CW]
- `tail` in CH: per-channel end-of-frame pulse, one cycle
- `fifo_empty` in CH: per-channel FIFO empty flag
- `req_valid` out 1: request pending toward the write engine
- `req_ready` in 1: engine accepts the request (resp)
- `req_ch` out CHW: channel index of the current request
- `req_len` out LSIZE: beat count of the current request
- `req_tail` out 1: 1 = tail flush, 0 = full burst
- `done` in 1: engine finished the accepted transfer, one-cycle pulse
- `tail_ack` out CH: one-cycle pulse when channel i's tail flush completes
- `busy` out 1: high in every state except IDLE

## Operation
- Registered per-channel flags, updated every cycle:
  - `burst_elig[i] <= count_i > THRESHOLD`
  - `tail_pend[i]` sets on `tail[i]`.
  - `tail_pend[i]` clears when a tail request for channel i is accepted, or when IDLE evaluates it with `count_i == 0`.
  - If a set and a clear coincide, set wins.
- Channel i is eligible when `!fifo_empty[i] && (burst_elig[i] || (tail_pend[i] && count_i != 0))`.
- State machine: IDLE, REQ, WAIT_DONE, FSH.
  - **IDLE:** if any channel is eligible, grant the first eligible channel searching upward from `last_grant+1` modulo CH, then go to REQ. Otherwise stay in IDLE.
    - Burst type wins within a channel: if `burst_elig` is set, latch `req_len = THRESHOLD` and `req_tail = 0`.
    - Otherwise latch `req_len = count_i` (low LSIZE bits) and `req_tail = 1`.
  - **REQ:** `req_valid` = 1. `req_ch`, `req_len` and `req_tail` are held stable until `req_ready`. On `req_ready`, update `last_grant`, clear `tail_pend` if this is a tail request, and go to WAIT_DONE.
  - **WAIT_DONE:** wait for `done`, then go to FSH.
  - **FSH:** one cycle. Pulse `tail_ack[req_ch]` if `req_tail`, then go to IDLE.
- A channel whose tail is pending but whose count exceeds THRESHOLD is served with full bursts first. The tail request follows once the count is ≤ THRESHOLD; the flag stays set meanwhile.
- `done` outside WAIT_DONE is ignored. `req_ready` outside REQ is ignored.
- `last_grant` resets to CH-1, so channel 0 is searched first after reset.

## Timing
- Reset values: `req_valid`, `req_ch`, `req_len`, `req_tail`, `tail_ack`, `busy` = 0. State is IDLE; all flags are clear.
- Count crossing THRESHOLD at edge n → `burst_elig` at n+1 → grant decided in IDLE at n+1 → `req_valid` high from edge n+2.
- `req_ready` on the same cycle that `req_valid` rises is accepted (0 wait).
- Minimum request-to-request spacing is 4 cycles: REQ, WAIT_DONE with `done` immediate, FSH, IDLE.
- Count changes after the grant do not alter the latched `req_len`.
- Deasserting `rst_n` mid-transfer returns every output to its reset value asynchronously. Pending tails are lost.

## Test plan
- CH=2: ch0 count 0→201, `req_ready` and `done` immediate → one request with ch=0, len=200, tail=0; `req_valid` rises 2 cycles after the crossing.
- Both channels at count 250, holding → grants alternate 0,1,0,1. No channel is granted twice in a row.
- ch1 count 37, `tail[1]` pulse → request with ch=1, len=37, tail=1, then `tail_ack[1]` pulse in FSH.
- ch0 count 300 plus `tail[0]` → burst of len 200, tail=0 first. When the count falls to 100, a tail request with len=100 follows.
- `tail[0]` with count 0 → no request issued and `tail_pend[0]` cleared. `tail[0]` repeated during its own accept cycle → a second tail request is issued later.
- Hold `req_ready` low 5 cycles and change count meanwhile → `req_*` outputs stay stable. Assert `rst_n` low in WAIT_DONE → all outputs return to 0 immediately.
